// File: rtl/serial_addsub_seq_if.sv
// serial_addsub_seq_if: request/result bundle between the requester and the bit-serial add/sub sequencer.
interface serial_addsub_seq_if #(parameter int WIDTH = 4);
  logic start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic operacion;
  logic busy;
  logic done;
  logic [WIDTH-1:0] S;
  logic Cout;
  modport master (output start, A, B, operacion, input busy, done, S, Cout);
  modport slave (input start, A, B, operacion, output busy, done, S, Cout);
endinterface

// File: rtl/serial_addsub_seq.sv
// serial_addsub_seq: bit-serial add/subtract, one full-adder slice reused LSB first with carry/borrow held in a flop.
module serial_addsub_seq #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst,
  serial_addsub_seq_if.slave io
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic op_q, op_d, c_q, c_d, cout_q, cout_d, done_q, done_d;
  logic sb, ax, cn;
  // Operands shift right so the active bit is always at position 0; ax folds the borrow rule into the carry rule.
  assign sb = a_q[0] ^ b_q[0] ^ c_q;
  assign ax = a_q[0] ^ op_q;
  assign cn = (ax & b_q[0]) | (ax & c_q) | (b_q[0] & c_q);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    c_d = c_q;
    cnt_d = cnt_q;
    r_d = r_q;
    s_d = s_q;
    cout_d = cout_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (io.start) begin
        state_d = RUN;
        a_d = io.A;
        b_d = io.B;
        op_d = io.operacion;
        c_d = 1'b0;
        cnt_d = '0;
      end
    end else begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      c_d = cn;
      r_d = (r_q >> 1) | (WIDTH'(sb) << (WIDTH - 1));
      cnt_d = cnt_q == CW'(WIDTH - 1) ? cnt_q : cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = IDLE;
        s_d = r_d;
        cout_d = cn;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= 1'b0;
      c_q <= 1'b0;
      cnt_q <= '0;
      r_q <= '0;
      s_q <= '0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      c_q <= c_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      s_q <= s_d;
      cout_q <= cout_d;
      done_q <= done_d;
    end
  end
  assign io.busy = state_q == RUN;
  assign io.done = done_q;
  assign io.S = s_q;
  assign io.Cout = cout_q;
endmodule
